unary_pair_encoder: RTL
=======================

Name: unary_pair_encoder

Overview:
- Upstream stage of the unary adder.
- Accepts a pair of binary operands over a valid/ready handshake and serialises each into a return-to-zero unary pulse stream on A and B.
- Drives the adder's en and read_or_write controls: accumulate phase first, then a fixed-length read phase.
- Signals completion so the next operand pair can be issued.

Parameters:
- WIDTH, 7, operand width in bits; maximum value per operand is 2^WIDTH-1.
- READ_CYCLES, 20, number of cycles read_or_write is held high in the read phase; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present on a_val/b_val.
- in_ready  output  1  block can accept a pair; high only in IDLE.
- a_val  input  WIDTH  binary operand for stream A.
- b_val  input  WIDTH  binary operand for stream B.
- A  output  1  unary pulse stream A (to adder).
- B  output  1  unary pulse stream B (to adder).
- en  output  1  adder enable.
- read_or_write  output  1  0 = accumulate, 1 = read out.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of read phase.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - A=B=en=read_or_write=done=0.
  - Internal counters and phase bit go to 0.
  - in_ready=1 once rst_n is released.
- A, B, en, read_or_write and done are registered. in_ready and busy decode directly from the state register.
- Handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1. a_val and b_val are captured into a_cnt and b_cnt. in_valid outside IDLE is ignored, with no side effects.
- State IDLE:
  - in_ready=1; all outputs 0.
  - On transfer, go to SEND with phase=0.
- State SEND (en=1, read_or_write=0):
  - Phase-0 cycle, with at least one count nonzero:
    - A <= (a_cnt!=0), B <= (b_cnt!=0).
    - Decrement each nonzero count.
    - phase <= 1.
  - Phase-0 cycle with a_cnt=b_cnt=0: go to READ; A=B=0.
  - Phase-1 cycle: A=B=0, phase <= 0.
  - Each unit of value therefore produces exactly one high cycle followed by one low cycle.
  - The two streams are aligned: both pulse on the same cycle while both counts are nonzero.
  - The shorter stream then stays low while the longer one finishes.
- State READ:
  - en=1, read_or_write=1, A=B=0 for exactly READ_CYCLES cycles, counted by an internal read counter.
  - Then go to DONE.
- State DONE:
  - done=1, en=1, read_or_write=1 for one cycle.
  - Then IDLE: en, read_or_write and done return to 0.
- Timing:
  - Handshake at edge k: first A/B high cycle is k+1 (if operand nonzero).
  - SEND lasts 2*max(a,b)+1 cycles including the terminating phase-0 check.
  - Total busy time = 2*max(a,b) + 1 + READ_CYCLES + 1 cycles.
- Counting invariant: the number of A high cycles per transaction equals a_val exactly, and the number of B high cycles equals b_val exactly.
- Boundary conditions:
  - a=b=0: SEND lasts one cycle with no pulses, then READ.
  - a or b = 2^WIDTH-1: no counter wrap; counts stop at 0.
  - Back-to-back transactions: a new pair can be accepted on the first IDLE cycle after DONE, so in_ready is low during DONE.
  - Reset mid-operation (any state): immediate return to IDLE with all outputs 0. A partial stream is abandoned, and no done pulse is produced.

Test Plan:
- Reset then a=3, b=5 -> A high on 3 cycles and B on 5, each high followed by a low; the first 3 B pulses coincide with A; SEND is 11 cycles; read_or_write high 20 cycles; done pulses once; in_ready returns to 1.
- a=0, b=0 -> no A/B pulses; en high; read_or_write high 20 cycles after 1 SEND cycle; done once; busy total 22 cycles.
- a=127, b=127 -> exactly 127 high cycles on each stream, never two consecutive highs; SEND 255 cycles; no wrap.
- in_valid=1 with a=9 held throughout a transaction of a=2, b=1 -> only 2/1 pulses emitted; the second pair is accepted on the first IDLE cycle after done; back-to-back transaction correct.
- rst_n asserted during SEND after 2 A pulses of a=6 -> A, B, en, read_or_write drop to 0 immediately (asynchronously); no done; next transaction a=1, b=1 is correct from a clean state.
- READ_CYCLES=1 override with a=1, b=0 -> one A pulse, B never high, read_or_write high 2 cycles (READ+DONE), done on the second.

Source files
------------

// File: rtl/unary_pair_encoder_if.sv
// Operand handshake and adder-facing control/stream signals of the unary pair encoder.
interface unary_pair_encoder_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             A;
  logic             B;
  logic             en;
  logic             read_or_write;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, a_val, b_val,
    input  in_ready, A, B, en, read_or_write, busy, done
  );

  modport slave (
    input  in_valid, a_val, b_val,
    output in_ready, A, B, en, read_or_write, busy, done
  );
endinterface

// File: rtl/unary_pair_encoder.sv
// Serialises a pair of binary operands into aligned return-to-zero unary pulse
// streams, then sequences the adder through a fixed-length read phase.
module unary_pair_encoder #(
  parameter int WIDTH       = 7,
  parameter int READ_CYCLES = 20
) (
  input logic               clk,
  input logic               rst_n,
  unary_pair_encoder_if.slave bus
);
  localparam int RW = $clog2(READ_CYCLES) + 1;
  localparam logic [RW-1:0] RD_LAST = RW'(READ_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, READ, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_cnt_reg, a_cnt_next;
  logic [WIDTH-1:0] b_cnt_reg, b_cnt_next;
  logic             phase_reg, phase_next;
  logic [RW-1:0]    rd_cnt_reg, rd_cnt_next;
  logic             a_reg, a_next;
  logic             b_reg, b_next;
  logic             en_reg, en_next;
  logic             row_reg, row_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_cnt_reg  <= '0;
      b_cnt_reg  <= '0;
      phase_reg  <= 1'b0;
      rd_cnt_reg <= '0;
      a_reg      <= 1'b0;
      b_reg      <= 1'b0;
      en_reg     <= 1'b0;
      row_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_cnt_reg  <= a_cnt_next;
      b_cnt_reg  <= b_cnt_next;
      phase_reg  <= phase_next;
      rd_cnt_reg <= rd_cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      en_reg     <= en_next;
      row_reg    <= row_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_cnt_next  = a_cnt_reg;
    b_cnt_next  = b_cnt_reg;
    phase_next  = phase_reg;
    rd_cnt_next = rd_cnt_reg;
    a_next      = 1'b0;
    b_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_cnt_next = bus.a_val;
          b_cnt_next = bus.b_val;
          phase_next = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        // Phase 1 is the return-to-zero half of each unit pulse.
        if (phase_reg) begin
          phase_next = 1'b0;
        end else if (a_cnt_reg != '0 || b_cnt_reg != '0) begin
          a_next     = (a_cnt_reg != '0);
          b_next     = (b_cnt_reg != '0);
          if (a_cnt_reg != '0) a_cnt_next = a_cnt_reg - 1'b1;
          if (b_cnt_reg != '0) b_cnt_next = b_cnt_reg - 1'b1;
          phase_next = 1'b1;
        end else begin
          rd_cnt_next = '0;
          state_next  = READ;
        end
      end
      READ: begin
        if (rd_cnt_reg == RD_LAST) begin
          rd_cnt_next = '0;
          state_next  = DONE;
        end else begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state register.
  always_comb begin
    en_next   = (state_next != IDLE);
    row_next  = (state_next == READ) || (state_next == DONE);
    done_next = (state_next == DONE);
  end

  assign bus.in_ready      = (state_reg == IDLE);
  assign bus.busy          = (state_reg != IDLE);
  assign bus.A             = a_reg;
  assign bus.B             = b_reg;
  assign bus.en            = en_reg;
  assign bus.read_or_write = row_reg;
  assign bus.done          = done_reg;
endmodule
